pdm_cic_decimator: RTL and testbench

- Upstream neighbour of the per-channel delay line in the mic-array beamformer.
- Converts one microphone's 1-bit PDM stream into 19-bit signed PCM.
- Uses a 3rd-order CIC filter: three integrators run at the PDM rate, three combs run at the decimated rate.
- Output feeds `pcm_data` of the delay line; one instance per microphone.

---
 rtl/pdm_cic_decimator.sv | 133 +++++++++++++
 tb/tb_pdm_cic_decimator.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator
// Turns one microphone's 1-bit PDM stream into signed PCM with a 3rd-order
// CIC filter. Three integrators run on every PDM strobe; a short comb FSM
// runs once per decimation frame and produces a one-cycle pcm_valid pulse.
// Datapath arithmetic is modulo 2^OUT_W on purpose: integrator wrap cancels
// in the combs as long as 3*log2(DECIM)+1 == OUT_W.
module pdm_cic_decimator #(
    parameter int DECIM = 64,
    parameter int OUT_W = 19
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pdm_en,
    input  logic                    pdm_in,
    output logic signed [OUT_W-1:0] pcm_data,
    output logic                    pcm_valid
);

    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);
    localparam logic [OUT_W-1:0] DC_OFFSET = OUT_W'(1) << (OUT_W - 2);

    typedef enum logic [2:0] {
        IDLE,
        CAP,
        C1,
        C2,
        C3
    } comb_state_t;

    comb_state_t state_q;
    comb_state_t state_d;

    logic [CNT_W-1:0] cnt;
    logic [OUT_W-1:0] i1;
    logic [OUT_W-1:0] i2;
    logic [OUT_W-1:0] i3;
    logic [OUT_W-1:0] samp;
    logic [OUT_W-1:0] d1;
    logic [OUT_W-1:0] d2;
    logic [OUT_W-1:0] d3;
    logic [OUT_W-1:0] c1;
    logic [OUT_W-1:0] c2;
    logic [OUT_W-1:0] comb3;
    logic [OUT_W-1:0] pdm_ext;
    logic             decim_evt;

    // A PDM '1' adds +1 to the first integrator, a '0' adds nothing.
    assign pdm_ext   = {{(OUT_W-1){1'b0}}, pdm_in};

    // The strobe that completes a frame of DECIM samples starts the comb.
    assign decim_evt = pdm_en && (cnt == CNT_LAST);

    // The third comb stage output is only needed on the C3 edge, so it is
    // formed combinationally instead of being stored.
    assign comb3     = c2 - d3;

    // Integrator chain and frame counter advance only on PDM strobes; each
    // stage adds the pre-edge value of the stage in front of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            i1  <= '0;
            i2  <= '0;
            i3  <= '0;
            cnt <= '0;
        end else if (pdm_en) begin
            i1  <= i1 + pdm_ext;
            i2  <= i2 + i1;
            i3  <= i3 + i2;
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    // Comb sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Comb sequencer next state: one pass IDLE->CAP->C1->C2->C3 per frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (decim_evt) state_d = CAP;
            CAP:     state_d = C1;
            C1:      state_d = C2;
            C2:      state_d = C3;
            C3:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Comb datapath: capture, three differencing stages, DC removal and the
    // output pulse; pcm_data holds between frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp      <= '0;
            d1        <= '0;
            d2        <= '0;
            d3        <= '0;
            c1        <= '0;
            c2        <= '0;
            pcm_data  <= '0;
            pcm_valid <= 1'b0;
        end else begin
            pcm_valid <= 1'b0;
            case (state_q)
                CAP: begin
                    samp <= i3;
                end
                C1: begin
                    c1 <= samp - d1;
                    d1 <= samp;
                end
                C2: begin
                    c2 <= c1 - d2;
                    d2 <= c1;
                end
                C3: begin
                    d3        <= c2;
                    pcm_data  <= $signed(comb3 - DC_OFFSET);
                    pcm_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// tb_pdm_cic_decimator
// Drives PDM streams into the decimator and compares every cycle against a
// reference built from the CIC impulse response (three cascaded length-DECIM
// boxcars, two-sample integrator lag, zero history after reset).
module tb_pdm_cic_decimator;

    localparam int DECIM  = 64;
    localparam int OUT_W  = 19;
    localparam int HLEN   = 3 * (DECIM - 1) + 1;
    localparam int XDEPTH = 8192;
    localparam logic [OUT_W-1:0] POS_FS = 19'h20000;
    localparam logic [OUT_W-1:0] NEG_FS = 19'h60000;

    logic             clk = 1'b0;
    logic             rst;
    logic             pdm_en;
    logic             pdm_in;
    logic [OUT_W-1:0] pcm_data;
    logic             pcm_valid;

    int checks   = 0;
    int failures = 0;

    int  h [HLEN];
    bit  xs [XDEPTH];
    int  nSamp;
    int  edgeNum;
    int  pulseIdx;
    int  expEdge [$];
    logic [OUT_W-1:0] expVal [$];
    logic [OUT_W-1:0] lastData;
    bit               steadyOn;
    logic [OUT_W-1:0] steadyVal;

    pdm_cic_decimator #(
        .DECIM(DECIM),
        .OUT_W(OUT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pdm_en   (pdm_en),
        .pdm_in   (pdm_in),
        .pcm_data (pcm_data),
        .pcm_valid(pcm_valid)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h edge=%0d",
                     tag, actual, expected, edgeNum);
        end
    endtask

    // Filter output for the frame ending at sample n, offset to DC-centred.
    function automatic logic [OUT_W-1:0] cicRef(input int n);
        int y;
        int idx;
        y = 0;
        for (int k = 0; k < HLEN; k++) begin
            idx = n - 2 - k;
            if (idx >= 1) y += h[k] * int'(xs[idx]);
        end
        return OUT_W'(y - (1 << (OUT_W - 2)));
    endfunction

    // Impulse response of three cascaded boxcars of length DECIM.
    task automatic buildImpulse();
        int b2 [2*DECIM-1];
        for (int i = 0; i < 2*DECIM-1; i++) b2[i] = 0;
        for (int i = 0; i < DECIM; i++)
            for (int j = 0; j < DECIM; j++) b2[i+j] += 1;
        for (int i = 0; i < HLEN; i++) h[i] = 0;
        for (int i = 0; i < 2*DECIM-1; i++)
            for (int j = 0; j < DECIM; j++) h[i+j] += b2[i];
    endtask

    // One clock: drive inputs, update the model at the edge, check at negedge.
    task automatic applyStimulus(input logic r, input logic en, input logic b);
        rst    = r;
        pdm_en = en;
        pdm_in = b;
        @(posedge clk);
        edgeNum++;
        if (r) begin
            nSamp    = 0;
            pulseIdx = 0;
            lastData = '0;
            expEdge.delete();
            expVal.delete();
        end else if (en) begin
            nSamp++;
            xs[nSamp] = b;
            if (nSamp % DECIM == 0) begin
                expEdge.push_back(edgeNum + 4);
                expVal.push_back(cicRef(nSamp));
            end
        end
        @(negedge clk);
        if (expEdge.size() > 0 && expEdge[0] == edgeNum) begin
            checkOutput("valid_pulse", 32'(pcm_valid), 32'd1);
            checkOutput("pcm_data", 32'(pcm_data), 32'(expVal[0]));
            lastData = expVal[0];
            pulseIdx++;
            if (steadyOn && pulseIdx >= 5 && pulseIdx <= 10)
                checkOutput("steady", 32'(pcm_data), 32'(steadyVal));
            void'(expEdge.pop_front());
            void'(expVal.pop_front());
        end else begin
            checkOutput("valid_idle", 32'(pcm_valid), 32'd0);
            checkOutput("hold", 32'(pcm_data), 32'(lastData));
        end
    endtask

    // Runs a number of frames of one stream type.
    // mode: 0 all ones, 1 all zeros, 2 alternating 1,0, 3 random.
    task automatic runPhase(input int mode, input int enPeriod, input int frames,
                            input bit doReset, input bit stOn,
                            input logic [OUT_W-1:0] stVal);
        int cyc;
        int target;
        int density;
        logic en;
        logic b;
        steadyOn  = stOn;
        steadyVal = stVal;
        if (doReset) applyStimulus(1'b1, 1'b0, 1'b0);
        target  = nSamp + frames * DECIM;
        density = $urandom_range(10, 90);
        cyc     = 0;
        while (nSamp < target && cyc < 20000) begin
            if (mode == 3) en = ($urandom_range(0, 2) != 0);
            else           en = ((cyc % enPeriod) == 0);
            case (mode)
                0:       b = 1'b1;
                1:       b = 1'b0;
                2:       b = ((nSamp % 2) == 0);
                default: b = ($urandom_range(0, 99) < density);
            endcase
            applyStimulus(1'b0, en, b);
            cyc++;
        end
        checkOutput("phase_done", 32'(nSamp >= target), 32'd1);
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        pdm_en   = 1'b0;
        pdm_in   = 1'b0;
        nSamp    = 0;
        edgeNum  = 0;
        pulseIdx = 0;
        lastData = '0;
        steadyOn = 1'b0;
        steadyVal = '0;
        buildImpulse();

        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("reset_valid", 32'(pcm_valid), 32'd0);
        checkOutput("reset_data", 32'(pcm_data), 32'd0);

        runPhase(0, 1, 12, 1'b1, 1'b1, POS_FS);
        runPhase(1, 1, 12, 1'b1, 1'b1, NEG_FS);
        runPhase(2, 1, 12, 1'b1, 1'b1, '0);
        runPhase(0, 4, 12, 1'b1, 1'b1, POS_FS);

        // Reset lands two edges after the third decimation event.
        steadyOn  = 1'b1;
        steadyVal = POS_FS;
        applyStimulus(1'b1, 1'b0, 1'b0);
        while (nSamp < 3 * DECIM) applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        runPhase(0, 1, 12, 1'b0, 1'b1, POS_FS);

        runPhase(3, 1, 10, 1'b1, 1'b0, '0);
        runPhase(3, 1, 10, 1'b1, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
